// File: rtl/memory_out.sv
// Result-sink buffer: captures a valid-only burst into a DEPTH-entry memory at
// sequential addresses and offers a registered readback port.
module memory_out #(
   parameter int WIDTH      = 256,
   parameter int DEPTH      = 8,
   parameter int log2_DEPTH = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [log2_DEPTH-1:0] num_of_dat,
   input  logic [WIDTH-1:0]      dat_in,
   input  logic                  dat_in_vld,
   output logic                  busy,
   output logic [log2_DEPTH-1:0] wr_cnt,
   output logic                  done,
   output logic                  err,
   input  logic                  rd_en,
   input  logic [log2_DEPTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_dat,
   output logic                  rd_dat_vld
);

   // state   | meaning
   // IDLE    | not armed; stray valid words are dropped and flagged in err
   // CAPTURE | armed; each valid word is written at wr_cnt until the last index
   typedef enum logic {IDLE, CAPTURE} state_t;

   state_t                state, state_nxt;
   logic [log2_DEPTH-1:0] len, len_nxt;
   logic [log2_DEPTH-1:0] wr_cnt_nxt;
   logic                  done_nxt;
   logic                  err_nxt;
   logic                  mem_we;
   logic [WIDTH-1:0]      mem [DEPTH];

   always_comb begin
      state_nxt  = state;
      len_nxt    = len;
      wr_cnt_nxt = wr_cnt;
      done_nxt   = 1'b0;
      err_nxt    = err;
      mem_we     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               len_nxt    = num_of_dat;
               wr_cnt_nxt = '0;
               err_nxt    = 1'b0;
               state_nxt  = CAPTURE;
            end
            // a stray word wins over the start-clear in the same cycle
            if (dat_in_vld) err_nxt = 1'b1;
         end
         CAPTURE: begin
            if (dat_in_vld) begin
               mem_we = 1'b1;
               if (wr_cnt == len) begin
                  wr_cnt_nxt = '0;
                  done_nxt   = 1'b1;
                  state_nxt  = IDLE;
               end else begin
                  wr_cnt_nxt = wr_cnt + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         len    <= '0;
         wr_cnt <= '0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= state_nxt;
         len    <= len_nxt;
         wr_cnt <= wr_cnt_nxt;
         done   <= done_nxt;
         err    <= err_nxt;
      end
   end

   assign busy = (state == CAPTURE);

   // storage is deliberately not reset so a mid-capture reset keeps earlier words
   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_cnt] <= dat_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_dat     <= '0;
         rd_dat_vld <= 1'b0;
      end else begin
         rd_dat_vld <= rd_en;
         if (rd_en) rd_dat <= mem[rd_addr];
      end
   end

endmodule

// File: tb/tb_memory_out.sv
// Scoreboard bench for memory_out: directed bursts plus randomized captures,
// compared against a burst-level reference model.
module tb_memory_out;
   localparam int W = 256;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [2:0]   num_of_dat = '0;
   logic [W-1:0] dat_in = '0;
   logic         dat_in_vld = 1'b0;
   logic         busy;
   logic [2:0]   wr_cnt;
   logic         done;
   logic         err;
   logic         rd_en = 1'b0;
   logic [2:0]   rd_addr = '0;
   logic [W-1:0] rd_dat;
   logic         rd_dat_vld;

   memory_out #(.WIDTH(W), .DEPTH(8), .log2_DEPTH(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_of_dat(num_of_dat),
      .dat_in(dat_in), .dat_in_vld(dat_in_vld), .busy(busy), .wr_cnt(wr_cnt),
      .done(done), .err(err), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_dat(rd_dat), .rd_dat_vld(rd_dat_vld)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // reference model: burst-level view of the capture
   logic [W-1:0] m_mem [8];
   bit           m_busy = 0;
   bit           m_err = 0;
   bit           m_rdv = 0;
   int           m_len = 0;
   int           m_wr = 0;
   logic [W-1:0] rq[$];
   int           dq[$];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd_word();
      logic [W-1:0] w = '0;
      for (int i = 0; i < W / 32; i++) w = {w[W-33:0], 32'($urandom())};
      return w;
   endfunction

   // one clock of stimulus; the model advances to the state after the next edge
   task automatic drive(input bit st, input int nd, input bit vld, input logic [W-1:0] d,
                        input bit re, input int ra);
      @(negedge clk);
      start = st; num_of_dat = nd[2:0]; dat_in_vld = vld; dat_in = d;
      rd_en = re; rd_addr = ra[2:0];
      if (re) rq.push_back(m_mem[ra[2:0]]);
      m_rdv = re;
      if (!m_busy) begin
         if (st) begin
            m_err = 0; m_busy = 1; m_len = nd + 1; m_wr = 0;
         end
         if (vld) m_err = 1;
      end else if (vld) begin
         m_mem[m_wr] = d;
         m_wr++;
         if (m_wr == m_len) begin
            m_wr = 0; m_busy = 0; dq.push_back(cyc + 1);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, '0, 0, 0);
   endtask

   task automatic rd(input int a);
      drive(0, 0, 0, '0, 1, a);
   endtask

   task automatic word(input logic [W-1:0] d);
      drive(0, 0, 1, d, 0, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; start = 0; dat_in_vld = 0; rd_en = 0;
      m_busy = 0; m_err = 0; m_wr = 0; m_rdv = 0; m_len = 0;
      dq.delete(); rq.delete();
      #1;
      chk("rst_rd_dat", rd_dat, '0);
      chk("rst_busy", busy, 0);
      chk("rst_wr_cnt", wr_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   always @(posedge clk) begin
      cyc++;
      #1;
      chk("busy", busy, m_busy);
      chk("err", err, m_err);
      chk("wr_cnt", wr_cnt, m_wr);
      chk("rd_dat_vld", rd_dat_vld, m_rdv);
      if (dq.size() > 0 && dq[0] == cyc) begin
         chk("done", done, 1);
         void'(dq.pop_front());
      end else begin
         chk("done", done, 0);
      end
      if (rd_dat_vld) begin
         if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected at cycle %0d: got %0h expected no read", cyc, rd_dat);
         end else begin
            chk("rd_dat", rd_dat, rq.pop_front());
         end
      end
   end

   initial begin
      int guard;
      idle(3);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);

      // basic 4-word burst, then readback
      drive(1, 3, 0, '0, 0, 0);
      idle(1);
      for (int i = 0; i < 4; i++) word(W'(8'hA0 + i));
      idle(2);
      for (int i = 0; i < 4; i++) rd(i);
      idle(2);

      // full buffer with random gaps
      drive(1, 7, 0, '0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         idle($urandom_range(0, 3));
         word(rnd_word());
      end
      idle(2);
      for (int i = 0; i < 8; i++) rd(i);
      idle(2);

      // stray word in idle, then single-word capture
      word(rnd_word());
      idle(1);
      drive(1, 0, 0, '0, 0, 0);
      idle(1);
      word(rnd_word());
      idle(1);
      rd(0); rd(1);
      idle(2);

      // start coincident with a stray word
      drive(1, 1, 1, rnd_word(), 0, 0);
      word(rnd_word());
      idle(1);
      word(rnd_word());
      idle(1);
      rd(0); rd(1); rd(2);
      idle(2);

      // start re-pulsed mid-capture is ignored
      drive(1, 5, 0, '0, 0, 0);
      word(rnd_word()); word(rnd_word());
      drive(1, 2, 0, '0, 0, 0);
      for (int i = 0; i < 4; i++) word(rnd_word());
      idle(1);
      for (int i = 0; i < 6; i++) rd(i);
      idle(2);

      // reset mid-capture retains written entries
      drive(1, 5, 0, '0, 0, 0);
      for (int i = 0; i < 3; i++) word(rnd_word());
      idle(1);
      do_reset();
      idle(2);
      for (int i = 0; i < 3; i++) rd(i);
      idle(1);
      drive(1, 2, 0, '0, 0, 0);
      for (int i = 0; i < 3; i++) word(rnd_word());
      idle(1);
      for (int i = 0; i < 3; i++) rd(i);
      idle(2);

      // randomized captures with concurrent reads, stray starts and gaps
      for (int it = 0; it < 12; it++) begin
         for (int i = 0; i < int'($urandom_range(0, 3)); i++)
            drive(0, 0, ($urandom % 4) == 0, rnd_word(), $urandom % 2, $urandom % 8);
         drive(1, $urandom % 8, ($urandom % 4) == 0, rnd_word(), $urandom % 2, $urandom % 8);
         guard = 0;
         while (m_busy && guard < 200) begin
            drive(($urandom % 8) == 0, $urandom % 8, $urandom % 2, rnd_word(),
                  $urandom % 2, $urandom % 8);
            guard++;
         end
         if (guard >= 200) chk("capture_timeout", 1, 0);
      end
      idle(3);
      chk("rd_queue_empty", rq.size(), 0);
      chk("done_queue_empty", dq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/memory_out.md
Name: memory_out

Overview:
- Capture-side counterpart of the stream-out memory block: receives a burst of WIDTH-bit words on a valid-only stream and stores them in a DEPTH-entry buffer at sequential addresses starting at 0.
- Sits at the end of the CNN datapath, or in loopback benches, as the result sink.
- A registered readback port lets the host or bench retrieve stored words after capture.

Parameters:
WIDTH, 256, data word width in bits
DEPTH, 8, number of buffer entries
log2_DEPTH, 3, address/counter width; DEPTH must equal 2**log2_DEPTH

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse that arms a capture
num_of_dat  input  log2_DEPTH  index of the last word to capture; burst length is num_of_dat+1
dat_in  input  WIDTH  stream data
dat_in_vld  input  1  stream valid; one word is accepted per asserted cycle
busy  output  1  capture armed and not yet complete
wr_cnt  output  log2_DEPTH  address of the next word to be written
done  output  1  single-cycle pulse when the last word has been written
err  output  1  sticky flag: a valid word arrived while not armed
rd_en  input  1  readback request
rd_addr  input  log2_DEPTH  readback address
rd_dat  output  WIDTH  readback data
rd_dat_vld  output  1  rd_dat is valid

Behaviour:
- Reset is asynchronous, active-low. While reset is asserted: busy=0, wr_cnt=0, done=0, err=0, rd_dat=0, rd_dat_vld=0, FSM=IDLE, latched length=0.
- Buffer contents are not reset and are undefined after power-up. A reset asserted mid-capture aborts the capture with no done pulse; already-written entries are retained.
- FSM states:
  - IDLE: start=1 latches num_of_dat, sets wr_cnt=0, clears err, and moves to CAPTURE on the next edge. busy reads 1 from the cycle after start.
  - CAPTURE: each cycle with dat_in_vld=1 writes memory[wr_cnt]<=dat_in.
    - If wr_cnt equals the latched length, wr_cnt wraps to 0 and the FSM returns to IDLE.
    - Otherwise wr_cnt increments by 1.
    - Cycles with dat_in_vld=0 hold state; gaps in the stream are allowed.
- done is registered. It is high exactly one cycle, on the cycle after the last-word write edge; busy falls on that same cycle.
- start asserted in CAPTURE is ignored: no re-arm, the latched length is unchanged, err is unaffected.
- dat_in_vld=1 in IDLE: the word is dropped and err is set to 1.
  - This includes the cycle in which start is asserted. Set has priority over the start-clear, so err=1 after that edge.
- err holds until the next start, or until reset.
- num_of_dat=0 captures exactly one word. num_of_dat=DEPTH-1 fills the buffer. No write ever addresses beyond DEPTH-1.
- Readback:
  - rd_en=1 registers memory[rd_addr] into rd_dat. rd_dat_vld=1 on the next cycle.
  - rd_dat holds its value when rd_en=0; rd_dat_vld follows rd_en delayed by one cycle.
  - Readback is legal in any state. A read and a write to the same address in the same cycle return the old contents (read-before-write).
- Producer interface has no backpressure: every dat_in_vld cycle in CAPTURE is consumed.

Test Plan:
- Reset, then start with num_of_dat=3; drive 4 consecutive valid words 0xA0..0xA3 starting 2 cycles later -> done high exactly 1 cycle after the 4th word, busy falls with done, err=0, wr_cnt=0; readback of addr 0..3 returns 0xA0..0xA3 with rd_dat_vld one cycle after each rd_en.
- num_of_dat=7, 8 words with random 0–3 cycle vld gaps -> all 8 entries stored in order, a single done pulse, no early done during gaps.
- dat_in_vld pulsed in IDLE, then start, then a 1-word capture (num_of_dat=0) -> err=1 before start, cleared by start, done after the single word, only addr 0 overwritten.
- start and dat_in_vld in the same IDLE cycle, num_of_dat=1 -> coincident word not written, err=1, capture completes after the next 2 valid words.
- start re-pulsed mid-capture (num_of_dat=5, after 2 words) -> ignored; done after the 6th total word.
- rst_n asserted after 3 of 6 words -> busy=0, done never pulses, wr_cnt=0; entries 0..2 retained on readback; a new capture then works normally.
